// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - step/run execution control with button debounce (optional CPU_STEP_BREAKPOINT_EN)

module cpu_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronize, then accept a new level only after a full run of disagreeing cycles
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        prev_d  = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    // Rising edge of the debounced level; releases give nothing
    assign press = level_q & ~prev_q;
endmodule

module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 50000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic             program_finished,
`ifdef CPU_STEP_BREAKPOINT_EN
    input  logic [7:0]       pc,
    input  logic [7:0]       bp_addr,
    input  logic             bp_valid,
    output logic             bp_hit,
`endif
    output logic             step_pulse,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);
    localparam int DW = $clog2(RUN_DIV);

    typedef enum logic [1:0] {ST_STEP, ST_RUN, ST_HALT} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bp_hit_q, bp_hit_d;
    logic             step_press, run_press;
    logic             bp_match;

    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .press (step_press)
    );

    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_run),
        .press (run_press)
    );

`ifdef CPU_STEP_BREAKPOINT_EN
    assign bp_match = bp_valid && (pc == bp_addr);
    assign bp_hit   = bp_hit_q;
`else
    assign bp_match = 1'b0;
`endif

    // Next state: program_finished beats run press, which beats step press / divider pulse
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        pulse_d  = 1'b0;
        bp_hit_d = bp_hit_q;
        count_d  = count_q;
        case (state_q)
            ST_STEP: begin
                if (program_finished) begin
                    state_d = ST_HALT;
                end else if (run_press) begin
                    state_d  = ST_RUN;
                    div_d    = '0;
                    bp_hit_d = 1'b0;
                end else if (step_press) begin
                    pulse_d  = 1'b1;
                    bp_hit_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (program_finished) begin
                    state_d = ST_HALT;
                    div_d   = '0;
                end else if (run_press) begin
                    state_d  = ST_STEP;
                    div_d    = '0;
                    bp_hit_d = 1'b0;
                end else if (div_q == DW'(RUN_DIV - 1)) begin
                    div_d = '0;
                    if (bp_match) begin
                        state_d  = ST_STEP;
                        bp_hit_d = 1'b1;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_STEP;
                div_d   = '0;
            end
        endcase
        // Count rises together with the pulse it records and saturates at all-ones
        if (pulse_d && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Control state registers; reset aborts any burst or divide in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_STEP;
            div_q    <= '0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign step_pulse = pulse_q;
    assign running    = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALT);
    assign step_count = count_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
`timescale 1ns/1ps

module tb_cpu_step_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_run = 1'b0;
    logic       program_finished = 1'b0;
    logic       step_pulse;
    logic       running;
    logic       halted;
    logic [3:0] step_count;
`ifdef CPU_STEP_BREAKPOINT_EN
    logic [7:0] pc = 8'h00;
    logic [7:0] bp_addr = 8'h00;
    logic       bp_valid = 1'b0;
    logic       bp_hit;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_step         (btn_step),
        .btn_run          (btn_run),
        .program_finished (program_finished),
`ifdef CPU_STEP_BREAKPOINT_EN
        .pc               (pc),
        .bp_addr          (bp_addr),
        .bp_valid         (bp_valid),
        .bp_hit           (bp_hit),
`endif
        .step_pulse       (step_pulse),
        .running          (running),
        .halted           (halted),
        .step_count       (step_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, {31'd0, step_pulse}, 32'd0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pulse", {31'd0, step_pulse}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", {28'd0, step_count}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: held step press gives one pulse on the 7th edge, none on hold or release
        btn_step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("t1_pulse", {31'd0, step_pulse}, {31'd0, (i == 7)});
            if (i == 7) chk("t1_count_at_pulse", {28'd0, step_count}, 32'd1);
        end
        btn_step = 1'b0;
        idle(12, "t1_release_pulse");
        chk("t1_count", {28'd0, step_count}, 32'd1);

        // 2: short glitch is rejected, bounce then hold gives one pulse
        btn_step = 1'b1;
        repeat (3) @(negedge clk);
        btn_step = 1'b0;
        idle(12, "t2_glitch_pulse");
        chk("t2_glitch_count", {28'd0, step_count}, 32'd1);
        btn_step = 1'b1;
        @(negedge clk);
        btn_step = 1'b0;
        @(negedge clk);
        btn_step = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("t2_bounce_pulse", {31'd0, step_pulse}, {31'd0, (i == 7)});
        end
        btn_step = 1'b0;
        idle(10, "t2_release_pulse");
        chk("t2_bounce_count", {28'd0, step_count}, 32'd2);

        // 3: run mode, pulse every 3rd cycle, saturating count, stop on second press
        btn_run = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("t3_enter_running", {31'd0, running}, {31'd0, (i == 7)});
            chk("t3_enter_pulse", {31'd0, step_pulse}, 32'd0);
        end
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (j == 1) btn_run = 1'b0;
            chk("t3_run_pulse", {31'd0, step_pulse}, {31'd0, (j % 3 == 0)});
            if (j == 39) chk("t3_count_sat", {28'd0, step_count}, 32'd15);
        end
        chk("t3_count_final", {28'd0, step_count}, 32'd15);
        btn_run = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            chk("t3_stop_pulse", {31'd0, step_pulse}, {31'd0, (j == 1 || j == 4)});
            chk("t3_stop_running", {31'd0, running}, {31'd0, (j != 7)});
        end
        btn_run = 1'b0;
        idle(12, "t3_stopped_pulse");
        chk("t3_stopped_running", {31'd0, running}, 32'd0);

        // 4: divider restarts from zero; program_finished on terminal count halts
        btn_run = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("t4_enter_running", {31'd0, running}, {31'd0, (k == 7)});
        end
        btn_run = 1'b0;
        for (int m = 1; m <= 6; m++) begin
            @(negedge clk);
            chk("t4_pulse", {31'd0, step_pulse}, {31'd0, (m == 3)});
            chk("t4_halted", {31'd0, halted}, {31'd0, (m == 6)});
            if (m == 5) program_finished = 1'b1;
        end
        chk("t4_halt_running", {31'd0, running}, 32'd0);
        program_finished = 1'b0;
        btn_step = 1'b1;
        idle(10, "t4_halt_step_pulse");
        btn_step = 1'b0;
        idle(8, "t4_halt_idle_pulse");
        btn_run = 1'b1;
        idle(10, "t4_halt_run_pulse");
        btn_run = 1'b0;
        chk("t4_still_halted", {31'd0, halted}, 32'd1);
        chk("t4_halt_not_running", {31'd0, running}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_halted", {31'd0, halted}, 32'd0);
        chk("t4_rst_count", {28'd0, step_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 5: asynchronous reset mid-divide and mid-debounce, then full latency again
        btn_run = 1'b1;
        repeat (7) @(negedge clk);
        chk("t5_running", {31'd0, running}, 32'd1);
        btn_run = 1'b0;
        btn_step = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_count_before", {28'd0, step_count}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_running", {31'd0, running}, 32'd0);
        chk("t5_rst_count", {28'd0, step_count}, 32'd0);
        chk("t5_rst_pulse", {31'd0, step_pulse}, 32'd0);
        btn_step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        btn_step = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("t5_latency_pulse", {31'd0, step_pulse}, {31'd0, (i == 7)});
        end
        btn_step = 1'b0;
        idle(10, "t5_release_pulse");

`ifdef CPU_STEP_BREAKPOINT_EN
        // 6: breakpoint at terminal count drops back to STEP without a pulse
        bp_valid = 1'b1;
        bp_addr  = 8'h0C;
        pc       = 8'h0C;
        btn_run  = 1'b1;
        repeat (7) @(negedge clk);
        chk("t6_running", {31'd0, running}, 32'd1);
        btn_run = 1'b0;
        for (int m = 1; m <= 6; m++) begin
            @(negedge clk);
            chk("t6_pulse", {31'd0, step_pulse}, 32'd0);
            chk("t6_running_m", {31'd0, running}, {31'd0, (m < 3)});
            chk("t6_bp_hit", {31'd0, bp_hit}, {31'd0, (m >= 3)});
        end
        btn_step = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t6_step_pulse", {31'd0, step_pulse}, {31'd0, (i == 7)});
            chk("t6_bp_clear", {31'd0, bp_hit}, {31'd0, (i < 7)});
        end
        btn_step = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
